// File: rtl/async_fifo_pkg.sv
// Shared async FIFO package: pointer width defaults and Gray/binary helpers.
// Helpers take zero-extended operands, so one pair serves any pointer width.
package async_fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DATASIZE_DEF = 8;
    localparam int PTR_MAXW     = 32;

    function automatic logic [PTR_MAXW-1:0] bin2gray(
        input logic [PTR_MAXW-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits stay zero, so narrower pointers convert correctly.
    function automatic logic [PTR_MAXW-1:0] gray2bin(
        input logic [PTR_MAXW-1:0] g
    );
        logic [PTR_MAXW-1:0] b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_sync_2ff.sv
// Two-flop synchroniser, parameterised width; reused on both FIFO sides.
// Each bit is only safe because the source is a Gray-coded pointer.
module async_fifo_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/async_fifo_rptr_empty.sv
// Async FIFO read side: pointer sync, read pointers, empty flag, FWFT output.
// Define RLEVEL_EN to add the conservative fill-level output rlevel.
module async_fifo_rptr_empty
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef RLEVEL_EN
    ,
    output logic [ADDRSIZE:0]   rlevel
`endif
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]       rq2_wptr;
    logic [PW-1:0]       rbin_q;
    logic [PW-1:0]       rbin_d;
    logic [PW-1:0]       rgray_q;
    logic [PW-1:0]       rgray_d;
    logic                rempty_q;
    logic                rempty_d;
    logic                valid_q;
    logic                valid_d;
    logic [DATASIZE-1:0] data_q;
    logic [DATASIZE-1:0] data_d;
    logic                pop;

    async_fifo_sync_2ff #(
        .WIDTH (PW)
    ) u_sync (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr_gray),
        .q    (rq2_wptr)
    );

    // Empty compares the next pointer, so the flag rises on the last pop.
    always_comb begin
        pop      = !rempty_q && (!valid_q || out_ready);
        rbin_d   = rbin_q + PW'(pop);
        rgray_d  = PW'(bin2gray(PTR_MAXW'(rbin_d)));
        rempty_d = (rgray_d == rq2_wptr);
        data_d   = data_q;
        valid_d  = valid_q;
        if (pop) begin
            data_d  = rdata;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= rempty_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

`ifdef RLEVEL_EN
    logic [PW-1:0] rlevel_q;
    logic [PW-1:0] rlevel_d;

    always_comb begin
        rlevel_d = PW'(gray2bin(PTR_MAXW'(rq2_wptr))) - rbin_d;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rlevel_q <= '0;
        end else begin
            rlevel_q <= rlevel_d;
        end
    end

    assign rlevel = rlevel_q;
`endif

    assign raddr     = rbin_q[ADDRSIZE-1:0];
    assign rptr_gray = rgray_q;
    assign rempty    = rempty_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_async_fifo_rptr_empty.sv
// Bench for async_fifo_rptr_empty: memory model, write-pointer driver, scoreboard.
// Build with RLEVEL_EN defined to also check rlevel.
module tb_async_fifo_rptr_empty;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic [AW:0]   wptr_gray = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [AW:0]   rptr_gray;
    logic          rempty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef RLEVEL_EN
    logic [AW:0]   rlevel;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int wbin     = 0;
    int accepted = 0;

    always #5 rclk = ~rclk;

    assign rdata = mem[raddr];

    async_fifo_rptr_empty #(
        .DATASIZE (DW),
        .ADDRSIZE (AW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .raddr     (raddr),
        .rdata     (rdata),
        .rptr_gray (rptr_gray),
        .rempty    (rempty),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RLEVEL_EN
        ,
        .rlevel    (rlevel)
`endif
    );

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = (AW+1)'(b);
        return x ^ (x >> 1);
    endfunction

    // Write side model: store word, then publish the advanced Gray pointer.
    task automatic push_word(input logic [DW-1:0] d);
        mem[wbin % DEPTH] = d;
        exp_q.push_back(d);
        wbin++;
        wptr_gray = gray(wbin);
    endtask

    // One cycle, called at a falling edge; predicts the accept at the next rise.
    task automatic step(input bit rdy, input bit wr, input logic [DW-1:0] d);
        bit            hold;
        logic [DW-1:0] hold_data;
        logic [AW:0]   hold_ptr;
        logic [DW-1:0] exp;
        if (wr && (wbin - accepted) < DEPTH) push_word(d);
        out_ready = rdy;
        hold      = out_valid && !rdy;
        hold_data = out_data;
        hold_ptr  = rptr_gray;
        if (out_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_word: got %h want none", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL data_order: got %h want %h", out_data, exp);
                end
            end
            accepted++;
        end
        @(negedge rclk);
        if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_data ||
                rptr_gray !== hold_ptr) begin
                failures++;
                $display("FAIL backpressure_hold: got v=%b d=%h p=%h want v=1 d=%h p=%h",
                         out_valid, out_data, rptr_gray, hold_data, hold_ptr);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (rempty !== 1'b1 || out_valid !== 1'b0 || raddr !== '0 ||
            rptr_gray !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL %s: got e=%b v=%b a=%h p=%h d=%h want e=1 v=0 a=0 p=0 d=0",
                     tag, rempty, out_valid, raddr, rptr_gray, out_data);
        end
`ifdef RLEVEL_EN
        checks++;
        if (rlevel !== '0) begin
            failures++;
            $display("FAIL %s_rlevel: got %0d want 0", tag, rlevel);
        end
`endif
    endtask

    task automatic do_reset();
        rrst      = 1'b1;
        wptr_gray = '0;
        out_ready = 1'b0;
        wbin      = 0;
        accepted  = 0;
        exp_q.delete();
        repeat (2) @(negedge rclk);
        rrst = 1'b0;
        @(negedge rclk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        step(1'b1, 1'b0, '0);
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s_timeout: got %0d left want 0", tag, exp_q.size());
        end
        checks++;
        if (rempty !== 1'b1 || out_valid !== 1'b0 || rptr_gray !== gray(wbin)) begin
            failures++;
            $display("FAIL %s_end: got e=%b v=%b p=%h want e=1 v=0 p=%h",
                     tag, rempty, out_valid, rptr_gray, gray(wbin));
        end
`ifdef RLEVEL_EN
        checks++;
        if (rlevel !== '0) begin
            failures++;
            $display("FAIL %s_rlevel: got %0d want 0", tag, rlevel);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_state("reset");
    endtask

    task automatic test_single_word();
        push_word(8'hA5);
        repeat (3) @(negedge rclk);
        checks++;
        if (rempty !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_n2: got e=%b v=%b want e=0 v=0", rempty, out_valid);
        end
        @(negedge rclk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || rempty !== 1'b1 ||
            rptr_gray !== 5'h01) begin
            failures++;
            $display("FAIL single_n3: got v=%b d=%h e=%b p=%h want v=1 d=a5 e=1 p=01",
                     out_valid, out_data, rempty, rptr_gray);
        end
        step(1'b0, 1'b0, '0);
        drain("single");
    endtask

    task automatic test_full_drain();
        int n = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_word(8'($urandom));
        while (!out_valid && n < 10) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_drain_gap: got v=%b at word %0d want 1", out_valid, i);
            end
            step(1'b1, 1'b0, '0);
        end
        checks++;
        if (rptr_gray !== 5'h18 || rempty !== 1'b1 || accepted != DEPTH) begin
            failures++;
            $display("FAIL full_drain_end: got p=%h e=%b n=%0d want p=18 e=1 n=16",
                     rptr_gray, rempty, accepted);
        end
        drain("full_drain");
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'($urandom));
        repeat (5) step(1'b0, 1'b0, '0);
        while (exp_q.size() != 0 && n < 100) begin
            step(n[0] == 1'b0, 1'b0, '0);
            n++;
        end
        checks++;
        if (accepted != 8 || rptr_gray !== gray(8)) begin
            failures++;
            $display("FAIL backpressure_count: got n=%0d p=%h want n=8 p=%h",
                     accepted, rptr_gray, gray(8));
        end
        drain("backpressure");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) push_word(8'($urandom));
            drain("wrap");
            checks++;
            if (rptr_gray[AW] !== 1'((p + 1) % 2)) begin
                failures++;
                $display("FAIL wrap_msb: got %b want %0d", rptr_gray[AW], (p + 1) % 2);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 8'($urandom));
        end
        drain("random");
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        do_reset();
        for (int i = 0; i < 10; i++) push_word(8'($urandom));
        while (accepted < 5 && n < 40) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (accepted != 5 || out_valid !== 1'b1 || rptr_gray !== gray(6)) begin
            failures++;
            $display("FAIL mid_drain_state: got n=%0d v=%b p=%h want n=5 v=1 p=%h",
                     accepted, out_valid, rptr_gray, gray(6));
        end
`ifdef RLEVEL_EN
        checks++;
        if (rlevel !== 5'd4) begin
            failures++;
            $display("FAIL mid_drain_rlevel: got %0d want 4", rlevel);
        end
`endif
        rrst      = 1'b1;
        wptr_gray = '0;
        #1;
        check_reset_state("mid_reset");
        do_reset();
        check_reset_state("after_reset");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single_word();
        test_full_drain();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
